// File: rtl/sb_line_monitor.sv
// sb_line_monitor
//
// Watches the sideband line coming up from the electrical layer and decides
// whether a link partner is present. A connect is declared only after the
// synchronized line has been high for CONNECT_CYC consecutive cycles. A
// disconnect is declared only after it has been low for DISCONNECT_CYC
// consecutive cycles. A high pulse too short to connect is reported as a
// measured pulse. A low dip while connected that is too short to disconnect
// is counted as a glitch.
//
// Parameters
//   CONNECT_CYC     consecutive high samples that qualify a connect (2..255)
//   DISCONNECT_CYC  consecutive low samples that qualify a disconnect (2..255)
//
// Ports
//   SystemClock     block clock, everything on the rising edge
//   SystemReset     asynchronous active-low reset
//   sb_en           monitor enable; low parks the FSM in DISC
//   sbtx            raw sideband level, asynchronous to SystemClock
//   connected       qualified link-partner-present level
//   connect_evt     one-cycle strobe when a connect qualifies
//   disconnect_evt  one-cycle strobe when a disconnect qualifies
//   pulse_valid     one-cycle strobe when a short high pulse ends
//   pulse_width     width in cycles of the last short pulse
//   glitch_cnt      saturating count of rejected low glitches while connected

module sb_line_monitor #(
  parameter int CONNECT_CYC    = 16,
  parameter int DISCONNECT_CYC = 32
) (
  input  logic       SystemClock,
  input  logic       SystemReset,
  input  logic       sb_en,
  input  logic       sbtx,
  output logic       connected,
  output logic       connect_evt,
  output logic       disconnect_evt,
  output logic       pulse_valid,
  output logic [7:0] pulse_width,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    DISC      = 2'd0,
    HIGH_QUAL = 2'd1,
    CONN      = 2'd2,
    LOW_QUAL  = 2'd3
  } lineState_t;

  // The run counter starts at 1 on entry to a qualifying state, so the final
  // qualifying sample is the one seen while the counter holds CYC-1.
  localparam logic [7:0] CONNECT_LAST    = 8'(CONNECT_CYC - 1);
  localparam logic [7:0] DISCONNECT_LAST = 8'(DISCONNECT_CYC - 1);
  localparam logic [7:0] GLITCH_MAX      = 8'hFF;

  logic       syncMeta;
  logic       syncLine;

  lineState_t state;
  lineState_t nextState;
  logic [7:0] cnt;
  logic [7:0] nextCnt;

  logic       connectedNext;
  logic       connectEvtNext;
  logic       disconnectEvtNext;
  logic       pulseValidNext;
  logic [7:0] pulseWidthNext;
  logic [7:0] glitchCntNext;

  // Two-flop synchronizer for the asynchronous line. It keeps running while
  // the monitor is disabled so that a fresh enable sees a settled level.
  always_ff @(posedge SystemClock or negedge SystemReset) begin
    if (!SystemReset) begin
      syncMeta <= 1'b0;
      syncLine <= 1'b0;
    end else begin
      syncMeta <= sbtx;
      syncLine <= syncMeta;
    end
  end

  // State register, run counter and all registered outputs. Reset clears
  // everything without producing any strobe.
  always_ff @(posedge SystemClock or negedge SystemReset) begin
    if (!SystemReset) begin
      state          <= DISC;
      cnt            <= 8'd0;
      connected      <= 1'b0;
      connect_evt    <= 1'b0;
      disconnect_evt <= 1'b0;
      pulse_valid    <= 1'b0;
      pulse_width    <= 8'd0;
      glitch_cnt     <= 8'd0;
    end else begin
      state          <= nextState;
      cnt            <= nextCnt;
      connected      <= connectedNext;
      connect_evt    <= connectEvtNext;
      disconnect_evt <= disconnectEvtNext;
      pulse_valid    <= pulseValidNext;
      pulse_width    <= pulseWidthNext;
      glitch_cnt     <= glitchCntNext;
    end
  end

  // Next-state and run-counter logic. The counter is cleared whenever the
  // FSM settles in DISC or CONN so that each qualification starts from 1.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    if (!sb_en) begin
      nextState = DISC;
      nextCnt   = 8'd0;
    end else begin
      case (state)
        DISC: begin
          if (syncLine) begin
            nextState = HIGH_QUAL;
            nextCnt   = 8'd1;
          end
        end
        HIGH_QUAL: begin
          if (!syncLine) begin
            nextState = DISC;
            nextCnt   = 8'd0;
          end else if (cnt == CONNECT_LAST) begin
            nextState = CONN;
            nextCnt   = 8'd0;
          end else begin
            nextCnt = cnt + 8'd1;
          end
        end
        CONN: begin
          if (!syncLine) begin
            nextState = LOW_QUAL;
            nextCnt   = 8'd1;
          end
        end
        LOW_QUAL: begin
          if (syncLine) begin
            nextState = CONN;
            nextCnt   = 8'd0;
          end else if (cnt == DISCONNECT_LAST) begin
            nextState = DISC;
            nextCnt   = 8'd0;
          end else begin
            nextCnt = cnt + 8'd1;
          end
        end
        default: begin
          nextState = DISC;
          nextCnt   = 8'd0;
        end
      endcase
    end
  end

  // Next values of the registered outputs. connected follows the next state,
  // so it stays high through LOW_QUAL and drops together with the FSM when
  // the monitor is disabled. Each strobe belongs to a different transition
  // out of a single state, so at most one can fire per cycle.
  always_comb begin
    connectedNext     = (nextState == CONN) || (nextState == LOW_QUAL);
    connectEvtNext    = 1'b0;
    disconnectEvtNext = 1'b0;
    pulseValidNext    = 1'b0;
    pulseWidthNext    = pulse_width;
    glitchCntNext     = glitch_cnt;
    if (sb_en) begin
      case (state)
        HIGH_QUAL: begin
          if (!syncLine) begin
            pulseValidNext = 1'b1;
            pulseWidthNext = cnt;
          end else if (cnt == CONNECT_LAST) begin
            connectEvtNext = 1'b1;
          end
        end
        LOW_QUAL: begin
          if (syncLine) begin
            if (glitch_cnt != GLITCH_MAX) begin
              glitchCntNext = glitch_cnt + 8'd1;
            end
          end else if (cnt == DISCONNECT_LAST) begin
            disconnectEvtNext = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_line_monitor.sv
// tb_sb_line_monitor
//
// Directed bench for sb_line_monitor at default parameters. Each task drives
// one scenario and compares outputs against hand-computed values. Edge
// numbering: cycleNo counts rising edges; an input changed just after edge
// k is first sampled at edge k+1.

module tb_sb_line_monitor;

  logic       SystemClock = 1'b0;
  logic       SystemReset;
  logic       sb_en;
  logic       sbtx;
  logic       connected;
  logic       connect_evt;
  logic       disconnect_evt;
  logic       pulse_valid;
  logic [7:0] pulse_width;
  logic [7:0] glitch_cnt;

  int errors = 0;
  int checks = 0;
  int cycleNo = 0;

  int connCount = 0;
  int discCount = 0;
  int pulseCount = 0;
  int overlapCount = 0;
  int lastConnCycle = 0;
  int lastDiscCycle = 0;
  int lastPulseCycle = 0;

  sb_line_monitor #(
    .CONNECT_CYC(16),
    .DISCONNECT_CYC(32)
  ) dut (
    .SystemClock(SystemClock),
    .SystemReset(SystemReset),
    .sb_en(sb_en),
    .sbtx(sbtx),
    .connected(connected),
    .connect_evt(connect_evt),
    .disconnect_evt(disconnect_evt),
    .pulse_valid(pulse_valid),
    .pulse_width(pulse_width),
    .glitch_cnt(glitch_cnt)
  );

  always #5 SystemClock = ~SystemClock;

  always @(posedge SystemClock) cycleNo = cycleNo + 1;

  // Strobe recorder, sampled mid-cycle; cycleNo is the edge that produced them.
  always @(negedge SystemClock) begin
    if (connect_evt === 1'b1) begin
      connCount = connCount + 1;
      lastConnCycle = cycleNo;
    end
    if (disconnect_evt === 1'b1) begin
      discCount = discCount + 1;
      lastDiscCycle = cycleNo;
    end
    if (pulse_valid === 1'b1) begin
      pulseCount = pulseCount + 1;
      lastPulseCycle = cycleNo;
    end
    if ((32'(connect_evt === 1'b1) + 32'(disconnect_evt === 1'b1) + 32'(pulse_valid === 1'b1)) > 1)
      overlapCount = overlapCount + 1;
  end

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge SystemClock);
      #1;
    end
  endtask

  task automatic test_reset;
    SystemReset = 1'b1;
    sb_en = 1'b0;
    sbtx = 1'b0;
    #2 SystemReset = 1'b0;
    #1;
    checks++; if (connected !== 1'b0) begin errors++; $display("[TB] FAIL reset_connected got %b expected 0", connected); end
    checks++; if (connect_evt !== 1'b0) begin errors++; $display("[TB] FAIL reset_connect_evt got %b expected 0", connect_evt); end
    checks++; if (disconnect_evt !== 1'b0) begin errors++; $display("[TB] FAIL reset_disconnect_evt got %b expected 0", disconnect_evt); end
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse_valid got %b expected 0", pulse_valid); end
    checks++; if (pulse_width !== 8'd0) begin errors++; $display("[TB] FAIL reset_pulse_width got %0d expected 0", pulse_width); end
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_glitch_cnt got %0d expected 0", glitch_cnt); end
    runCycles(3);
    SystemReset = 1'b1;
    runCycles(4);
    checks++; if (connected !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_connected got %b expected 0", connected); end
  endtask

  task automatic test_short_pulse;
    int n;
    int pulseBase;
    int connBase;
    sb_en = 1'b1;
    sbtx = 1'b0;
    runCycles(4);
    pulseBase = pulseCount;
    connBase = connCount;
    sbtx = 1'b1;
    n = cycleNo + 1;
    runCycles(10);
    sbtx = 1'b0;
    runCycles(20);
    checks++; if (pulseCount - pulseBase !== 1) begin errors++; $display("[TB] FAIL pulse_count got %0d expected 1", pulseCount - pulseBase); end
    checks++; if (lastPulseCycle - n !== 12) begin errors++; $display("[TB] FAIL pulse_latency got %0d expected 12", lastPulseCycle - n); end
    checks++; if (pulse_width !== 8'd10) begin errors++; $display("[TB] FAIL pulse_width got %0d expected 10", pulse_width); end
    checks++; if (connected !== 1'b0) begin errors++; $display("[TB] FAIL pulse_connected got %b expected 0", connected); end
    checks++; if (connCount - connBase !== 0) begin errors++; $display("[TB] FAIL pulse_no_connect got %0d expected 0", connCount - connBase); end
  endtask

  task automatic test_connect_disconnect;
    int n;
    int m;
    int connBase;
    int discBase;
    int pulseBase;
    connBase = connCount;
    discBase = discCount;
    pulseBase = pulseCount;
    sbtx = 1'b1;
    n = cycleNo + 1;
    runCycles(20);
    checks++; if (connected !== 1'b1) begin errors++; $display("[TB] FAIL cd_connected got %b expected 1", connected); end
    checks++; if (connCount - connBase !== 1) begin errors++; $display("[TB] FAIL cd_connect_count got %0d expected 1", connCount - connBase); end
    checks++; if (lastConnCycle - n !== 17) begin errors++; $display("[TB] FAIL cd_connect_latency got %0d expected 17", lastConnCycle - n); end
    sbtx = 1'b0;
    m = cycleNo + 1;
    runCycles(30);
    checks++; if (connected !== 1'b1) begin errors++; $display("[TB] FAIL cd_connected_lowqual got %b expected 1", connected); end
    runCycles(10);
    checks++; if (discCount - discBase !== 1) begin errors++; $display("[TB] FAIL cd_disconnect_count got %0d expected 1", discCount - discBase); end
    checks++; if (lastDiscCycle - m !== 33) begin errors++; $display("[TB] FAIL cd_disconnect_latency got %0d expected 33", lastDiscCycle - m); end
    checks++; if (connected !== 1'b0) begin errors++; $display("[TB] FAIL cd_disconnected got %b expected 0", connected); end
    checks++; if (pulseCount - pulseBase !== 0) begin errors++; $display("[TB] FAIL cd_no_pulse got %0d expected 0", pulseCount - pulseBase); end
  endtask

  task automatic test_glitch;
    int discBase;
    sbtx = 1'b1;
    runCycles(20);
    discBase = discCount;
    sbtx = 1'b0;
    runCycles(31);
    sbtx = 1'b1;
    runCycles(6);
    checks++; if (discCount - discBase !== 0) begin errors++; $display("[TB] FAIL glitch_no_disconnect got %0d expected 0", discCount - discBase); end
    checks++; if (connected !== 1'b1) begin errors++; $display("[TB] FAIL glitch_connected got %b expected 1", connected); end
    checks++; if (glitch_cnt !== 8'd1) begin errors++; $display("[TB] FAIL glitch_cnt got %0d expected 1", glitch_cnt); end
  endtask

  task automatic test_glitch_saturate;
    int discBase;
    discBase = discCount;
    for (int i = 0; i < 300; i++) begin
      sbtx = 1'b0;
      runCycles(5);
      sbtx = 1'b1;
      runCycles(2);
      if (i == 252) begin
        runCycles(3);
        checks++; if (glitch_cnt !== 8'd254) begin errors++; $display("[TB] FAIL glitch_cnt_254 got %0d expected 254", glitch_cnt); end
      end
    end
    runCycles(5);
    checks++; if (glitch_cnt !== 8'd255) begin errors++; $display("[TB] FAIL glitch_saturate got %0d expected 255", glitch_cnt); end
    checks++; if (connected !== 1'b1) begin errors++; $display("[TB] FAIL saturate_connected got %b expected 1", connected); end
    checks++; if (discCount - discBase !== 0) begin errors++; $display("[TB] FAIL saturate_no_disconnect got %0d expected 0", discCount - discBase); end
  endtask

  task automatic test_enable_drop;
    int e;
    int connBase;
    int discBase;
    discBase = discCount;
    connBase = connCount;
    sb_en = 1'b0;
    runCycles(1);
    checks++; if (connected !== 1'b0) begin errors++; $display("[TB] FAIL en_drop_connected got %b expected 0", connected); end
    runCycles(5);
    checks++; if (discCount - discBase !== 0) begin errors++; $display("[TB] FAIL en_drop_no_disconnect got %0d expected 0", discCount - discBase); end
    checks++; if (glitch_cnt !== 8'd255) begin errors++; $display("[TB] FAIL en_drop_glitch_hold got %0d expected 255", glitch_cnt); end
    checks++; if (pulse_width !== 8'd10) begin errors++; $display("[TB] FAIL en_drop_width_hold got %0d expected 10", pulse_width); end
    sb_en = 1'b1;
    e = cycleNo + 1;
    runCycles(20);
    checks++; if (connCount - connBase !== 1) begin errors++; $display("[TB] FAIL en_rise_connect_count got %0d expected 1", connCount - connBase); end
    checks++; if (lastConnCycle - e !== 15) begin errors++; $display("[TB] FAIL en_rise_connect_edge got %0d expected 15", lastConnCycle - e); end
    checks++; if (connected !== 1'b1) begin errors++; $display("[TB] FAIL en_rise_connected got %b expected 1", connected); end
  endtask

  task automatic test_reset_midqual;
    int r;
    int connBase;
    int pulseBase;
    sbtx = 1'b0;
    runCycles(40);
    connBase = connCount;
    pulseBase = pulseCount;
    sbtx = 1'b1;
    runCycles(10);
    SystemReset = 1'b0;
    #1;
    checks++; if (pulse_width !== 8'd0) begin errors++; $display("[TB] FAIL midreset_pulse_width got %0d expected 0", pulse_width); end
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("[TB] FAIL midreset_glitch_cnt got %0d expected 0", glitch_cnt); end
    checks++; if (connected !== 1'b0) begin errors++; $display("[TB] FAIL midreset_connected got %b expected 0", connected); end
    runCycles(3);
    SystemReset = 1'b1;
    r = cycleNo + 1;
    runCycles(25);
    checks++; if (connCount - connBase !== 1) begin errors++; $display("[TB] FAIL midreset_connect_count got %0d expected 1", connCount - connBase); end
    checks++; if (lastConnCycle - r !== 17) begin errors++; $display("[TB] FAIL midreset_connect_latency got %0d expected 17", lastConnCycle - r); end
    checks++; if (pulseCount - pulseBase !== 0) begin errors++; $display("[TB] FAIL midreset_no_pulse got %0d expected 0", pulseCount - pulseBase); end
  endtask

  task automatic test_strobe_exclusive;
    checks++; if (overlapCount !== 0) begin errors++; $display("[TB] FAIL strobe_overlap got %0d expected 0", overlapCount); end
  endtask

  // Scenarios run in order; each leaves the line in a known state for the next.
  initial begin
    test_reset;
    test_short_pulse;
    test_connect_disconnect;
    test_glitch;
    test_glitch_saturate;
    test_enable_drop;
    test_reset_midqual;
    test_strobe_exclusive;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
